m6502_alu_sequencer: RTL and testbench

Fetch/execute sequencer for the 6502 ALU instruction group (opcode bits `cc = 01`). It drives the operand, carry and operation inputs of the 6502 ALU and retires its result into the accumulator and flags. It owns the program counter and a byte-wide memory read port, and steps instruction by instruction while `run` is high. This release supports ADC in immediate, zero-page and absolute modes; every other opcode halts the block.

---
 rtl/m6502_pkg.sv | 36 +++
 rtl/m6502_bcd_adjust.sv | 33 +++
 rtl/m6502_alu_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_m6502_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m6502_pkg.sv
// m6502_pkg -- shared definitions for the 6502 ALU-group sequencer.
//
// Contents:
//   state_t          sequencer states (DEC_ADJ is only reachable when the
//                    M6502_DECIMAL_EN macro is defined)
//   ALU_ADC          ALU operation code {aaa, cc} for ADC
//   CC_ALU           opcode[1:0] group code of the ALU instruction group
//   MODE_*           addressing-mode encodings of opcode[4:2]
//   is_legal_op()    true for the opcodes this release executes
package m6502_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_FETCH_LO,
        ST_FETCH_HI,
        ST_READ_DATA,
        ST_EXEC,
        ST_DEC_ADJ
    } state_t;

    localparam logic [4:0] ALU_ADC  = 5'b01101;
    localparam logic [1:0] CC_ALU   = 2'b01;

    localparam logic [2:0] MODE_ZP  = 3'b001;
    localparam logic [2:0] MODE_IMM = 3'b010;
    localparam logic [2:0] MODE_ABS = 3'b011;

    // ADC in immediate, zero-page or absolute mode; everything else halts.
    function automatic logic is_legal_op(input logic [7:0] op);
        logic mode_ok;
        mode_ok = (op[4:2] == MODE_IMM) || (op[4:2] == MODE_ZP) || (op[4:2] == MODE_ABS);
        return (op[1:0] == CC_ALU) && (op[7:5] == ALU_ADC[4:2]) && mode_ok;
    endfunction

endpackage

// File: rtl/m6502_bcd_adjust.sv
// m6502_bcd_adjust -- combinational decimal correction of a binary ADC sum.
//
// Ports:
//   sum         in  8  binary sum produced by the ALU
//   half_carry  in  1  carry out of the low nibble of the binary add
//   carry       in  1  carry out of the binary add
//   result      out 8  BCD-corrected sum
//   carry_out   out 1  decimal carry (set when the high nibble is corrected)
//
// Only instantiated when M6502_DECIMAL_EN is defined.
module m6502_bcd_adjust (
    input  logic [7:0] sum,
    input  logic       half_carry,
    input  logic       carry,
    output logic [7:0] result,
    output logic       carry_out
);

    logic       lo_fix;
    logic       hi_fix;
    logic [8:0] lo_fixed;

    always_comb begin
        lo_fix   = half_carry || (sum[3:0] > 4'd9);
        lo_fixed = {1'b0, sum} + (lo_fix ? 9'h006 : 9'h000);
        // The high-nibble test looks at the nibble after the low correction,
        // so a low-nibble ripple (e.g. 9A -> A0) is caught here.
        hi_fix    = carry || lo_fixed[8] || (lo_fixed[7:4] > 4'd9);
        result    = lo_fixed[7:0] + (hi_fix ? 8'h60 : 8'h00);
        carry_out = hi_fix;
    end

endmodule

// File: rtl/m6502_alu_sequencer.sv
// m6502_alu_sequencer -- fetch/execute sequencer for the 6502 ALU group.
//
// Fetches an opcode and its operand bytes over a byte-wide read port,
// drives an external ALU in EXEC and retires the sum into A and C/Z/N/V.
// Only ADC immediate/zero-page/absolute is executed; any other opcode sets
// the sticky halted flag.
//
// Configuration macro: M6502_DECIMAL_EN -- when defined, d_flag high adds a
// DEC_ADJ cycle that BCD-corrects A and C (Z/N/V keep binary values).
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   run                      start the next instruction (sampled in IDLE)
//   mem_addr/mem_rd          read request, held until mem_ready
//   mem_rdata/mem_ready      read data and its completion strobe
//   alu_operand1/2           A and M, valid in EXEC only (0 otherwise)
//   alu_carry_in             C flag, valid in EXEC only
//   alu_operation            {opcode[7:5], opcode[1:0]}, valid in EXEC only
//   alu_result/carry_out     ALU sum and carry
//   d_flag                   decimal mode (used only with M6502_DECIMAL_EN)
//   a_out, flag_c/z/n/v      accumulator and status flags
//   pc_out                   program counter
//   instr_done               one-cycle pulse in the retiring state
//   halted                   sticky illegal-opcode indicator
module m6502_alu_sequencer
    import m6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [7:0]  alu_operand1,
    output logic [7:0]  alu_operand2,
    output logic        alu_carry_in,
    output logic [4:0]  alu_operation,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry_out,
    input  logic        d_flag,
    output logic [7:0]  a_out,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v,
    output logic [15:0] pc_out,
    output logic        instr_done,
    output logic        halted
);

    state_t      state, state_next;
    logic [15:0] pc;
    logic [15:0] ea;
    logic [7:0]  acc;
    logic [7:0]  m_reg;
    logic [7:0]  opcode;

`ifdef M6502_DECIMAL_EN
    logic       half_c;
    logic [4:0] lo_sum;
    logic [7:0] bcd_result;
    logic       bcd_carry;

    assign lo_sum = {1'b0, acc[3:0]} + {1'b0, m_reg[3:0]} + {4'd0, flag_c};

    m6502_bcd_adjust u_bcd_adjust (
        .sum        (acc),
        .half_carry (half_c),
        .carry      (flag_c),
        .result     (bcd_result),
        .carry_out  (bcd_carry)
    );
`else
    logic unused_d_flag;
    assign unused_d_flag = d_flag;
`endif

    // Next state and Moore outputs.
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next    = state;
        mem_rd        = 1'b0;
        mem_addr      = pc;
        instr_done    = 1'b0;
        alu_operand1  = 8'h00;
        alu_operand2  = 8'h00;
        alu_carry_in  = 1'b0;
        alu_operation = 5'b00000;

        case (state)
            ST_IDLE: begin
                if (run && !halted) state_next = ST_FETCH_OP;
            end
            ST_FETCH_OP: begin
                mem_rd = 1'b1;
                if (mem_ready) state_next = is_legal_op(mem_rdata) ? ST_FETCH_LO : ST_IDLE;
            end
            ST_FETCH_LO: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    case (opcode[4:2])
                        MODE_IMM: state_next = ST_EXEC;
                        MODE_ZP:  state_next = ST_READ_DATA;
                        default:  state_next = ST_FETCH_HI;
                    endcase
                end
            end
            ST_FETCH_HI: begin
                mem_rd = 1'b1;
                if (mem_ready) state_next = ST_READ_DATA;
            end
            ST_READ_DATA: begin
                mem_rd   = 1'b1;
                mem_addr = ea;
                if (mem_ready) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                alu_operand1  = acc;
                alu_operand2  = m_reg;
                alu_carry_in  = flag_c;
                alu_operation = {opcode[7:5], opcode[1:0]};
`ifdef M6502_DECIMAL_EN
                state_next = d_flag ? ST_DEC_ADJ : ST_IDLE;
                instr_done = !d_flag;
`else
                state_next = ST_IDLE;
                instr_done = 1'b1;
`endif
            end
`ifdef M6502_DECIMAL_EN
            ST_DEC_ADJ: begin
                state_next = ST_IDLE;
                instr_done = 1'b1;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // State and architectural registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values (V below relies on the old A).
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            ea     <= 16'h0000;
            acc    <= 8'h00;
            m_reg  <= 8'h00;
            opcode <= 8'h00;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            halted <= 1'b0;
`ifdef M6502_DECIMAL_EN
            half_c <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                ST_FETCH_OP: if (mem_ready) begin
                    pc     <= pc + 16'd1;
                    opcode <= mem_rdata;
                    if (!is_legal_op(mem_rdata)) halted <= 1'b1;
                end
                ST_FETCH_LO: if (mem_ready) begin
                    // Low byte is both the immediate operand and the
                    // zero-page / absolute address low byte.
                    pc    <= pc + 16'd1;
                    m_reg <= mem_rdata;
                    ea    <= {8'h00, mem_rdata};
                end
                ST_FETCH_HI: if (mem_ready) begin
                    pc        <= pc + 16'd1;
                    ea[15:8]  <= mem_rdata;
                end
                ST_READ_DATA: if (mem_ready) begin
                    m_reg <= mem_rdata;
                end
                ST_EXEC: begin
                    acc    <= alu_result;
                    flag_c <= alu_carry_out;
                    flag_z <= (alu_result == 8'h00);
                    flag_n <= alu_result[7];
                    flag_v <= (acc[7] == m_reg[7]) && (alu_result[7] != acc[7]);
`ifdef M6502_DECIMAL_EN
                    half_c <= lo_sum[4];
`endif
                end
`ifdef M6502_DECIMAL_EN
                ST_DEC_ADJ: begin
                    acc    <= bcd_result;
                    flag_c <= bcd_carry;
                end
`endif
                default: ;
            endcase
        end
    end

    assign a_out  = acc;
    assign pc_out = pc;

endmodule

// File: tb/tb_m6502_alu_sequencer.sv
// tb_m6502_alu_sequencer -- self-checking bench for m6502_alu_sequencer.
// Provides a 64 KiB byte memory and a binary 8-bit adder as the external
// ALU; expected results come from a hand-written vector table and are
// queued as each instruction is issued, then compared when it retires.
module tb_m6502_alu_sequencer;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  data;
        logic        dec;
        int          stall_rd;   // index of the read to stall, -1 for none
        int          stall_n;
        logic [7:0]  exp_a;
        logic        exp_c;
        logic        exp_z;
        logic        exp_n;
        logic        exp_v;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic        c, z, n, v;
        logic [15:0] pc;
        int          lat;
        logic [7:0]  operand2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [7:0]  alu_operand1, alu_operand2;
    logic        alu_carry_in;
    logic [4:0]  alu_operation;
    logic [7:0]  alu_result;
    logic        alu_carry_out;
    logic        d_flag;
    logic [7:0]  a_out;
    logic        flag_c, flag_z, flag_n, flag_v;
    logic [15:0] pc_out;
    logic        instr_done;
    logic        halted;

    logic [7:0]  mem [0:65535];

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] pc_model;
    exp_t        exp_q [$];
    logic [15:0] exp_addr [$];
    logic [15:0] got_addr [$];
    logic [15:0] held_addr [$];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign {alu_carry_out, alu_result} = {1'b0, alu_operand1} + {1'b0, alu_operand2} + {8'd0, alu_carry_in};

    m6502_alu_sequencer #(.RESET_PC(16'h0200)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .alu_operand1  (alu_operand1),
        .alu_operand2  (alu_operand2),
        .alu_carry_in  (alu_carry_in),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .d_flag        (d_flag),
        .a_out         (a_out),
        .flag_c        (flag_c),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .flag_v        (flag_v),
        .pc_out        (pc_out),
        .instr_done    (instr_done),
        .halted        (halted)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Issue one instruction from the current PC and compare on retire.
    task automatic exec_one(input string tag, input vec_t v);
        logic [15:0] p, ea;
        logic [2:0]  mode;
        exp_t        e;
        int          cycles, stalls, rd_cnt;
        logic        found;
        p    = pc_model;
        mode = v.op[4:2];
        ea   = (mode == 3'b011) ? {v.hi, v.lo} : {8'h00, v.lo};
        mem[p]         = v.op;
        mem[p + 16'd1] = v.lo;
        exp_addr.delete();
        got_addr.delete();
        held_addr.delete();
        exp_addr.push_back(p);
        exp_addr.push_back(p + 16'd1);
        if (mode == 3'b011) begin
            mem[p + 16'd2] = v.hi;
            exp_addr.push_back(p + 16'd2);
        end
        if (mode != 3'b010) begin
            mem[ea] = v.data;
            exp_addr.push_back(ea);
        end
        e.a = v.exp_a; e.c = v.exp_c; e.z = v.exp_z; e.n = v.exp_n; e.v = v.exp_v;
        e.pc       = p + ((mode == 3'b011) ? 16'd3 : 16'd2);
        e.lat      = v.exp_lat;
        e.operand2 = (mode == 3'b010) ? v.lo : v.data;
        exp_q.push_back(e);

        d_flag = v.dec;
        stalls = v.stall_n;
        rd_cnt = 0;
        found  = 1'b0;
        cycles = 1;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                cycles++;
            end
            if (mem_rd && rd_cnt == v.stall_rd && stalls > 0) begin
                mem_ready = 1'b0;
                stalls--;
                held_addr.push_back(mem_addr);
            end else begin
                mem_ready = 1'b1;
            end
            if (mem_rd && mem_ready) begin
                got_addr.push_back(mem_addr);
                rd_cnt++;
            end
            if (instr_done) begin
                found = 1'b1;
                if (!v.dec) begin
                    check({tag, " alu_operation"}, alu_operation, 5'b01101);
                    check({tag, " alu_operand2"}, alu_operand2, e.operand2);
                end
            end
        end
        mem_ready = 1'b1;
        e = exp_q.pop_front();
        check({tag, " retired"}, found, 1);
        check({tag, " latency"}, cycles, e.lat);
        @(posedge clk); #1;
        check({tag, " single pulse"}, instr_done, 0);
        check({tag, " A"}, a_out, e.a);
        check({tag, " C"}, flag_c, e.c);
        check({tag, " Z"}, flag_z, e.z);
        check({tag, " N"}, flag_n, e.n);
        check({tag, " V"}, flag_v, e.v);
        check({tag, " PC"}, pc_out, e.pc);
        check({tag, " read count"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            check($sformatf("%s addr%0d", tag, i), got_addr[i], exp_addr[i]);
        if (v.stall_n > 0) begin
            check({tag, " stall cycles"}, held_addr.size(), v.stall_n);
            for (int i = 0; i < held_addr.size(); i++)
                check($sformatf("%s held addr%0d", tag, i), held_addr[i], exp_addr[v.stall_rd]);
        end
        pc_model = e.pc;
    endtask

    vec_t vecs [10];
`ifdef M6502_DECIMAL_EN
    vec_t dvecs [4];
`endif

    initial begin
        int n_rd, n_done;
        //          op     lo     hi     data   dec  srd sn  A      C     Z     N     V     lat
        vecs[0] = '{8'h69, 8'h05, 8'h00, 8'h00, 1'b0, -1, 0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[1] = '{8'h69, 8'h7A, 8'h00, 8'h00, 1'b0, -1, 0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[2] = '{8'h69, 8'h01, 8'h00, 8'h00, 1'b0, -1, 0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 3};
        vecs[3] = '{8'h69, 8'h80, 8'h00, 8'h00, 1'b0, -1, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 3};
        vecs[4] = '{8'h69, 8'h00, 8'h00, 8'h00, 1'b0, -1, 0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[5] = '{8'h6D, 8'h34, 8'h12, 8'hFF, 1'b0, -1, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 5};
        vecs[6] = '{8'h65, 8'h10, 8'h00, 8'h3F, 1'b0,  2, 2, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 6};
        vecs[7] = '{8'h65, 8'h20, 8'h00, 8'hC0, 1'b0, -1, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4};
        vecs[8] = '{8'h6D, 8'h00, 8'h30, 8'h7F, 1'b0,  2, 1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 6};
        vecs[9] = '{8'h69, 8'hFF, 8'h00, 8'h00, 1'b0, -1, 0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 3};

        reset = 1'b1; run = 1'b0; d_flag = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("reset A", a_out, 8'h00);
        check("reset flags", {flag_c, flag_z, flag_n, flag_v}, 4'b0000);
        check("reset PC", pc_out, 16'h0200);
        check("reset mem_rd", mem_rd, 0);
        check("reset instr_done", instr_done, 0);
        check("reset halted", halted, 0);
        check("reset alu outputs", {alu_operand1, alu_operand2, alu_carry_in, alu_operation}, 0);

        pc_model = 16'h0200;
        for (int i = 0; i < 10; i++) exec_one($sformatf("v%0d", i), vecs[i]);

        // Illegal opcode: halts, PC steps past it, state untouched.
        mem[pc_model] = 8'hE9;
        run = 1'b1;
        n_rd = 0; n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k >= 1 && mem_rd) n_rd++;
            if (instr_done) n_done++;
        end
        run = 1'b0;
        check("halt halted", halted, 1);
        check("halt no reads", n_rd, 0);
        check("halt no retire", n_done, 0);
        check("halt A", a_out, vecs[9].exp_a);
        check("halt flags", {flag_c, flag_z, flag_n, flag_v},
              {vecs[9].exp_c, vecs[9].exp_z, vecs[9].exp_n, vecs[9].exp_v});
        check("halt PC", pc_out, pc_model + 16'd1);

        // Reset clears halted; then abandon an absolute ADC in FETCH_HI.
        reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
        check("rst halted", halted, 0);
        mem[16'h0200] = 8'h6D; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h40; mem[16'h4000] = 8'h55;
        run = 1'b1; @(posedge clk); #1 run = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid fetch_hi addr", {mem_rd, mem_addr}, {1'b1, 16'h0202});
        reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
        check("mid mem_rd", mem_rd, 0);
        check("mid PC", pc_out, 16'h0200);
        check("mid halted", halted, 0);
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            if (instr_done) n_done++;
            @(posedge clk); #1;
        end
        check("mid no retire", n_done, 0);
        check("mid A", a_out, 8'h00);
        pc_model = 16'h0200;

`ifdef M6502_DECIMAL_EN
        dvecs[0] = '{8'h69, 8'h09, 8'h00, 8'h00, 1'b0, -1, 0, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        dvecs[1] = '{8'h69, 8'h01, 8'h00, 8'h00, 1'b1, -1, 0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        dvecs[2] = '{8'h69, 8'h89, 8'h00, 8'h00, 1'b0, -1, 0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        dvecs[3] = '{8'h69, 8'h01, 8'h00, 8'h00, 1'b1, -1, 0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4};
        for (int i = 0; i < 4; i++) exec_one($sformatf("d%0d", i), dvecs[i]);
        d_flag = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
